// File: rtl/timetag_readout_splitter.sv
`timescale 1ns/1ps
// timetag_readout_splitter
//
// Splits the merged timetag readout stream (one header beat, then the
// timestamp block, then the sample block, one last at frame end) back into a
// timestamp stream and a sample stream.
//
// Header beat layout: [COUNT_WIDTH-1:0] = N_T (timestamp words),
// [2*COUNT_WIDTH-1:COUNT_WIDTH] = N_S (sample words), upper bits ignored.
// The header is consumed and never forwarded.
//
// Handshake rule for every stream below: a beat transfers on a rising edge of
// ps_clk where valid and ready are both 1. valid never waits on ready. Once
// valid is raised, data/last stay stable until the transfer. Payload is a
// combinational pass-through, so the readout ready is the active output's ready.
//
// Ports
//   ps_clk, ps_reset_n        clock, synchronous active-low reset
//   ps_readout_data_*         merged input stream (data/valid/ready/last)
//   ps_timestamps_*           timestamp output stream
//   ps_samples_*              sample output stream
//   ps_error_clear            one-cycle pulse, clears ps_frame_error
//   ps_frame_error            sticky framing error flag
//   ps_frame_done             one-cycle pulse per correctly terminated frame
//   ps_frame_count            good frame count, wraps at 2^16
//   dbg_state                 current FSM state (0 HEADER, 1 TSTAMP, 2 SAMPLE, 3 DRAIN)
module timetag_readout_splitter #(
  parameter int AXI_MM_WIDTH = 128,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                    ps_clk,
  input  logic                    ps_reset_n,
  input  logic [AXI_MM_WIDTH-1:0] ps_readout_data_data,
  input  logic                    ps_readout_data_valid,
  output logic                    ps_readout_data_ready,
  input  logic                    ps_readout_data_last,
  output logic [AXI_MM_WIDTH-1:0] ps_timestamps_data,
  output logic                    ps_timestamps_valid,
  input  logic                    ps_timestamps_ready,
  output logic                    ps_timestamps_last,
  output logic [AXI_MM_WIDTH-1:0] ps_samples_data,
  output logic                    ps_samples_valid,
  input  logic                    ps_samples_ready,
  output logic                    ps_samples_last,
  input  logic                    ps_error_clear,
  output logic                    ps_frame_error,
  output logic                    ps_frame_done,
  output logic [15:0]             ps_frame_count,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    ST_HEADER = 2'd0,
    ST_TSTAMP = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] t_rem_q, t_rem_d;
  logic [COUNT_WIDTH-1:0] s_rem_q, s_rem_d;
  logic                   run_q;
  logic                   error_q;
  logic                   done_q;
  logic [15:0]            count_q;

  logic                   active;
  logic                   err_set;
  logic                   good_end;
  logic [COUNT_WIDTH-1:0] hdr_nt;
  logic [COUNT_WIDTH-1:0] hdr_ns;
  logic                   ts_final;
  logic                   s_final;
  logic                   in_hs_ts;
  logic                   in_hs_s;

  // run_q holds everything idle for the first cycle after reset; the raw
  // ps_reset_n term keeps the handshake outputs quiet while reset is held.
  assign active   = run_q & ps_reset_n;

  assign hdr_nt   = ps_readout_data_data[COUNT_WIDTH-1:0];
  assign hdr_ns   = ps_readout_data_data[2*COUNT_WIDTH-1:COUNT_WIDTH];
  assign ts_final = (t_rem_q == CNT_ONE);
  assign s_final  = (s_rem_q == CNT_ONE);
  assign in_hs_ts = ps_readout_data_valid & ps_timestamps_ready;
  assign in_hs_s  = ps_readout_data_valid & ps_samples_ready;

  assign ps_timestamps_data = ps_readout_data_data;
  assign ps_samples_data    = ps_readout_data_data;

  always_comb begin
    state_d               = state_q;
    t_rem_d               = t_rem_q;
    s_rem_d               = s_rem_q;
    ps_readout_data_ready = 1'b0;
    ps_timestamps_valid   = 1'b0;
    ps_timestamps_last    = 1'b0;
    ps_samples_valid      = 1'b0;
    ps_samples_last       = 1'b0;
    err_set               = 1'b0;
    good_end              = 1'b0;
    if (active) begin
      case (state_q)
        ST_HEADER: begin
          ps_readout_data_ready = 1'b1;
          if (ps_readout_data_valid) begin
            if (ps_readout_data_last) begin
              // A one-beat frame is only legal when it announces no payload.
              if (hdr_nt == CNT_ZERO && hdr_ns == CNT_ZERO) good_end = 1'b1;
              else                                          err_set  = 1'b1;
            end else if (hdr_nt != CNT_ZERO) begin
              state_d = ST_TSTAMP;
              t_rem_d = hdr_nt;
              s_rem_d = hdr_ns;
            end else if (hdr_ns != CNT_ZERO) begin
              state_d = ST_SAMPLE;
              t_rem_d = CNT_ZERO;
              s_rem_d = hdr_ns;
            end else begin
              err_set = 1'b1;
              state_d = ST_DRAIN;
            end
          end
        end
        ST_TSTAMP: begin
          ps_timestamps_valid   = ps_readout_data_valid;
          ps_readout_data_ready = ps_timestamps_ready;
          // An early input last still closes the output packet cleanly.
          ps_timestamps_last    = ts_final | ps_readout_data_last;
          if (in_hs_ts) begin
            t_rem_d = t_rem_q - CNT_ONE;
            if (ps_readout_data_last) begin
              state_d = ST_HEADER;
              if (ts_final && s_rem_q == CNT_ZERO) good_end = 1'b1;
              else                                 err_set  = 1'b1;
            end else if (ts_final) begin
              if (s_rem_q != CNT_ZERO) begin
                state_d = ST_SAMPLE;
              end else begin
                err_set = 1'b1;
                state_d = ST_DRAIN;
              end
            end
          end
        end
        ST_SAMPLE: begin
          ps_samples_valid      = ps_readout_data_valid;
          ps_readout_data_ready = ps_samples_ready;
          ps_samples_last       = s_final | ps_readout_data_last;
          if (in_hs_s) begin
            s_rem_d = s_rem_q - CNT_ONE;
            if (ps_readout_data_last) begin
              state_d = ST_HEADER;
              if (s_final) good_end = 1'b1;
              else         err_set  = 1'b1;
            end else if (s_final) begin
              err_set = 1'b1;
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          ps_readout_data_ready = 1'b1;
          if (ps_readout_data_valid && ps_readout_data_last) state_d = ST_HEADER;
        end
        default: state_d = ST_HEADER;
      endcase
    end
  end

  always_ff @(posedge ps_clk) begin
    if (!ps_reset_n) begin
      state_q <= ST_HEADER;
      t_rem_q <= CNT_ZERO;
      s_rem_q <= CNT_ZERO;
      run_q   <= 1'b0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      t_rem_q <= t_rem_d;
      s_rem_q <= s_rem_d;
      run_q   <= 1'b1;
      done_q  <= good_end;
      if (good_end) count_q <= count_q + 16'd1;
      // A new error outranks a clear arriving in the same cycle.
      if (err_set)             error_q <= 1'b1;
      else if (ps_error_clear) error_q <= 1'b0;
    end
  end

  assign ps_frame_error = error_q;
  assign ps_frame_done  = done_q;
  assign ps_frame_count = count_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/timetag_readout_splitter.md
# timetag_readout_splitter

Consumer-side splitter for the merged timetag readout stream: accepts the single AXI-stream produced by the timetagging sample buffer (timestamp block followed by sample block, one `last` at frame end) and separates it back into a timestamp stream and a sample stream. It sits on the PS clock domain, downstream of the readout mux, and feeds on-fabric consumers such as the loopback checker and histogrammer. Frame boundaries come from a one-beat header carrying both block lengths. Frames that violate those lengths are flagged and discarded up to the next `last`.

## Interface
Parameters:
- AXI_MM_WIDTH, 128, width of every stream data bus; must be ≥ 2*COUNT_WIDTH
- COUNT_WIDTH, 32, width of each length field in the header

Ports (ps_clk single clock; reset synchronous, active-low, named ps_reset_n):
- ps_clk  input  1  PS clock (100 MHz)
- ps_reset_n  input  1  synchronous active-low reset
- ps_readout_data  Axis_If.Slave  AXI_MM_WIDTH  merged stream in (data/valid/ready/last)
- ps_timestamps  Axis_If.Master  AXI_MM_WIDTH  timestamp words out
- ps_samples  Axis_If.Master  AXI_MM_WIDTH  sample words out
- ps_error_clear  input  1  single-cycle pulse, clears ps_frame_error
- ps_frame_error  output  1  sticky framing error flag
- ps_frame_done  output  1  one-cycle pulse per correctly terminated frame
- ps_frame_count  output  16  count of good frames, wraps at 2^16

## Operation
- Header beat: N_T = data[COUNT_WIDTH-1:0] (timestamp words), N_S = data[2*COUNT_WIDTH-1:COUNT_WIDTH] (sample words); upper bits ignored. Header is consumed, never forwarded.
- FSM states: HEADER, TSTAMP, SAMPLE, DRAIN. Reset state HEADER.
- HEADER, ready=1:
  - header with last=1 and N_T=N_S=0 → good empty frame, stay HEADER.
  - header with last=1 and any count nonzero → error, stay HEADER.
  - last=0: → TSTAMP if N_T>0, else → SAMPLE if N_S>0, else error → DRAIN.
- TSTAMP: in.data→ps_timestamps.data; ps_timestamps.valid=in.valid; in.ready=ps_timestamps.ready; remaining counter decrements per handshake.
  - Final beat: ps_timestamps.last=1, then → SAMPLE if N_S>0, else frame ends (in.last must be 1).
- SAMPLE: same, routed to ps_samples; ps_samples.last=1 on final beat; in.last must be 1 on that beat.
- Error cases:
  - in.last=1 before the final beat: beat forwarded with out.last=1, error set → HEADER.
  - final beat with in.last=0: beat forwarded with out.last=1, error set → DRAIN.
- DRAIN: in.ready=1, nothing forwarded, → HEADER on the in.last handshake.
- Good frame end: ps_frame_done pulses, ps_frame_count increments.
- Inactive output always has valid=0; in HEADER and DRAIN both outputs have valid=0.
- Counters are COUNT_WIDTH bits; N=2^COUNT_WIDTH−1 is legal.
- Error/clear priority: error set wins over ps_error_clear in the same cycle.

## Timing
- Data path is combinational pass-through: zero latency from in to out in TSTAMP/SAMPLE. Backpressure propagates combinationally.
- Header costs one in-handshake cycle with no output.
- The TSTAMP→SAMPLE transition takes effect the cycle after the final timestamp handshake; no bubble is required beyond that.
- ps_frame_done is registered: it asserts the cycle after the terminating handshake.
- ps_frame_error and ps_frame_count are registered. The error sets the cycle after the offending handshake.
- Reset values while ps_reset_n=0 and on the first cycle after:
  - in.ready=0, all out.valid=0, out.last=0;
  - ps_frame_error=0, ps_frame_done=0, ps_frame_count=0;
  - state HEADER, counters 0.
- Reset mid-frame abandons the frame. The next accepted beat is treated as a header.

## Test plan
- Nominal: header N_T=3,N_S=5, then 8 beats with last on beat 8 → 3 beats on ps_timestamps (last on 3rd), 5 on ps_samples (last on 5th), frame_done pulses once, frame_count=1, error=0.
- N_S=0: header N_T=2,N_S=0, 2 beats with last on 2nd → ps_timestamps last on 2nd, no ps_samples traffic, good frame. Empty header with last → frame_count increments, no output.
- Random backpressure: 30% ready-low on each output, valid gaps on input, N_T=17,N_S=64 → byte-exact order preserved, no dropped or duplicated beats.
- Early last: header N_T=4,N_S=4, last on beat 6 → sample beat 2 carries out.last, error=1. Next good frame is parsed correctly and error stays set until ps_error_clear.
- Missing last: header N_T=1,N_S=1, 5 beats with last on 5th → 2 beats forwarded, beats 3–5 dropped, error=1, frame_count unchanged.
- Reset mid-frame (ps_reset_n low 1 cycle during SAMPLE), and error_clear coincident with a new error → all outputs return to reset values, next beat parsed as header. Error remains 1 in the coincident case.
